// File: rtl/hart_pkg.sv
// Shared hart-wide types and constants.
// Fetch entries carry the word, its PC and a misaligned-fetch flag.
package hart_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] CAUSE_INST_MISALIGNED = '0;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            trap;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush, count/full/empty.
// A push into a full FIFO is accepted only alongside a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_count   = r_wr - r_rd;
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign o_rdata   = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch front end: credit-limited requests, prefetch queue,
// redirect flush with stale-response dropping and misaligned trap entry.
module ifetch_queue
  import hart_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_drop;
  logic         r_halted;
  logic         r_trap_pend;
  logic [31:0]  r_trap_pc;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;
  logic          w_push;
  logic          w_accept;
  logic          w_resp;
  logic          w_stale;
  logic          w_live;
  logic          w_credit;
  logic [OW-1:0] w_out_next;
  int            w_inflight;

  // Reserve a queue slot for every response that will be kept.
  always_comb begin
    w_inflight = int'(w_count) + int'(r_out) - int'(r_drop);
    w_credit   = (w_inflight < DEPTH) &&
                 (int'(r_out) < MAX_OUTSTANDING);
  end

  assign o_mem_req  = !rst && !r_halted &&
                      !i_redirect_valid && w_credit;
  assign o_mem_addr = r_fetch_pc;
  assign w_accept   = o_mem_req && i_mem_ready;
  assign w_resp     = i_mem_rvalid && (r_out != '0);
  assign w_stale    = w_resp && (r_drop != '0);
  assign w_live     = w_resp && (r_drop == '0);

  always_comb begin
    w_out_next = r_out;
    unique case (1'b1)
      (w_accept && !w_resp): w_out_next = r_out + 1'b1;
      (!w_accept && w_resp): w_out_next = r_out - 1'b1;
      default:               w_out_next = r_out;
    endcase
  end

  always_comb begin
    w_wdata = '{inst: i_mem_rdata, pc: r_resp_pc, trap: 1'b0};
    if (r_trap_pend)
      w_wdata = '{inst: '0, pc: r_trap_pc, trap: 1'b1};
  end

  assign w_push = !i_redirect_valid && (r_trap_pend || w_live);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (i_inst_ready),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_inst_valid = !rst && !w_empty;
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;
  assign o_inst_trap  = o_inst_valid && w_head.trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_ADDR;
      r_resp_pc   <= RESET_ADDR;
      r_out       <= '0;
      r_drop      <= '0;
      r_halted    <= 1'b0;
      r_trap_pend <= 1'b0;
      r_trap_pc   <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc  <= i_redirect_pc;
      r_resp_pc   <= i_redirect_pc;
      r_out       <= w_out_next;
      r_drop      <= w_out_next;
      r_halted    <= (i_redirect_pc[1:0] != 2'b00);
      r_trap_pend <= (i_redirect_pc[1:0] != 2'b00);
      r_trap_pc   <= i_redirect_pc;
    end else begin
      r_out       <= w_out_next;
      r_trap_pend <= 1'b0;
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_stale)  r_drop     <= r_drop - 1'b1;
      if (w_live)   r_resp_pc  <= r_resp_pc + 32'd4;
    end
  end

  a_rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (rst)
    i_mem_rvalid |-> (r_out != '0)
  );

endmodule
